// File: rtl/p_mul.sv
// Packed unsigned shift-and-add multiplier: 1x32, 2x16, 4x8, 8x4 or 16x2-bit lanes,
// one operation in flight, full 2W-bit lane products returned as packed low/high words.
module p_mul (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        valid,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [4:0]  pw,
  output logic        ready,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic [4:0]  wm1_q, wm1_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  wm1_dec;

  logic [31:0] addend, sum, cout;
  logic [31:0] phi_step, plo_step, a_step;

  // Lane width minus one; doubles as a lane-offset mask and the initial counter value.
  always_comb begin
    if      (pw[0]) wm1_dec = 5'd31;
    else if (pw[1]) wm1_dec = 5'd15;
    else if (pw[2]) wm1_dec = 5'd7;
    else if (pw[3]) wm1_dec = 5'd3;
    else if (pw[4]) wm1_dec = 5'd1;
    else            wm1_dec = 5'd31;
  end

  // Lane-masked ripple adder: the carry is killed at every lane start.
  always_comb begin : lane_adder
    logic       c;
    logic [4:0] idx;
    c      = 1'b0;
    idx    = '0;
    addend = '0;
    sum    = '0;
    cout   = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      idx = 5'(i);
      if ((idx & wm1_q) == 5'd0) c = 1'b0;
      addend[idx] = b_q[idx] & a_q[idx & ~wm1_q];
      sum[idx]    = phi_q[idx] ^ addend[idx] ^ c;
      c           = (phi_q[idx] & addend[idx]) | (c & (phi_q[idx] ^ addend[idx]));
      cout[idx]   = c;
    end
  end

  // Lane-local right shift of {carry, sum, P_lo} and of A.
  always_comb begin : lane_shift
    logic [4:0] idx;
    idx      = '0;
    phi_step = '0;
    plo_step = '0;
    a_step   = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      idx = 5'(i);
      if ((idx & wm1_q) == wm1_q) begin
        phi_step[idx] = cout[idx];
        plo_step[idx] = sum[idx & ~wm1_q];
        a_step[idx]   = 1'b0;
      end else begin
        phi_step[idx] = sum[idx + 5'd1];
        plo_step[idx] = plo_q[idx + 5'd1];
        a_step[idx]   = a_q[idx + 5'd1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    wm1_d   = wm1_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          a_d     = lhs;
          b_d     = rhs;
          wm1_d   = wm1_dec;
          cnt_d   = wm1_dec;
          phi_d   = '0;
          plo_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d   = a_step;
        phi_d = phi_step;
        plo_d = plo_step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      wm1_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      wm1_q   <= wm1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready     = (state_q == DONE);
  assign result_lo = plo_q;
  assign result_hi = phi_q;

endmodule

// File: tb/tb_p_mul.sv
// Bench for p_mul: vector table plus reset/back-to-back sequences, checked through
// a scoreboard of expected products and ready latencies.
module tb_p_mul;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        valid;
  logic [31:0] lhs, rhs;
  logic [4:0]  pw;
  logic        ready;
  logic [31:0] result_lo, result_hi;

  always #5 g_clk = ~g_clk;

  p_mul dut (
    .g_clk    (g_clk),
    .g_reset  (g_reset),
    .valid    (valid),
    .lhs      (lhs),
    .rhs      (rhs),
    .pw       (pw),
    .ready    (ready),
    .result_lo(result_lo),
    .result_hi(result_hi)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int unsigned issue;
    int unsigned lat;
  } exp_t;

  typedef struct {
    logic [4:0]  pw;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  exp_t        sbq[$];
  vec_t        table_v[10];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;

  always @(posedge g_clk) cyc <= cyc + 1;

  function automatic int unsigned lane_w(input logic [4:0] p);
    if      (p[0]) return 32;
    else if (p[1]) return 16;
    else if (p[2]) return 8;
    else if (p[3]) return 4;
    else if (p[4]) return 2;
    else           return 32;
  endfunction

  function automatic void model(input logic [4:0] p, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi);
    int unsigned w;
    logic [63:0] m, ak, bk, pr;
    w  = lane_w(p);
    m  = (64'd1 << w) - 64'd1;
    lo = '0;
    hi = '0;
    for (int unsigned k = 0; k < 32 / w; k++) begin
      ak = (64'(a) >> (k * w)) & m;
      bk = (64'(b) >> (k * w)) & m;
      pr = ak * bk;
      lo = lo | 32'((pr & m) << (k * w));
      hi = hi | 32'(((pr >> w) & m) << (k * w));
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge g_clk) begin
    exp_t e;
    if (g_reset === 1'b0 && ready === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_ready", 64'(ready), 64'd0);
      end else begin
        e = sbq.pop_front();
        check("result_lo", 64'(result_lo), 64'(e.lo));
        check("result_hi", 64'(result_hi), 64'(e.hi));
        check("latency", 64'(cyc - e.issue), 64'(e.lat));
      end
    end
  end

  // Caller is at a negedge; the following posedge samples the request.
  task automatic drive(input logic [4:0] p, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lo, input logic [31:0] hi);
    exp_t e;
    pw    = p;
    lhs   = a;
    rhs   = b;
    valid = 1'b1;
    e.lo    = lo;
    e.hi    = hi;
    e.issue = cyc;
    e.lat   = lane_w(p) + 1;
    sbq.push_back(e);
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge g_clk);
      lhs = $urandom;
      rhs = $urandom;
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  task automatic run_one(input vec_t v);
    @(negedge g_clk);
    drive(v.pw, v.lhs, v.rhs, v.lo, v.hi);
    @(negedge g_clk);
    valid = 1'b0;
    drain(60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    int unsigned seen;
    logic [31:0] lo, hi;

    table_v[0] = '{5'b00001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
    table_v[1] = '{5'b00010, 32'h0003_FFFF, 32'h0005_FFFF, 32'h000F_0001, 32'h0000_FFFE};
    table_v[2] = '{5'b00100, 32'h0210_FF00, 32'h8010_FF7F, 32'h0000_0100, 32'h0101_FE00};
    table_v[3] = '{5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 32'hAAAA_AAAA};
    table_v[4] = '{5'b01000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1111_1111, 32'hEEEE_EEEE};
    table_v[5] = '{5'b00000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
    table_v[6] = '{5'b10110, 32'h0003_FFFF, 32'h0005_FFFF, 32'h000F_0001, 32'h0000_FFFE};
    table_v[7] = '{5'b01000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    for (int i = 8; i < 10; i++) begin
      table_v[i].pw  = (i == 8) ? 5'b00010 : 5'b10000;
      table_v[i].lhs = $urandom;
      table_v[i].rhs = $urandom;
      model(table_v[i].pw, table_v[i].lhs, table_v[i].rhs, lo, hi);
      table_v[i].lo = lo;
      table_v[i].hi = hi;
    end

    g_reset = 1'b1;
    valid   = 1'b0;
    pw      = '0;
    lhs     = '0;
    rhs     = '0;
    repeat (3) @(negedge g_clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_lo", 64'(result_lo), 64'd0);
    check("reset_hi", 64'(result_hi), 64'd0);
    g_reset = 1'b0;

    for (int i = 0; i < 10; i++) run_one(table_v[i]);

    // Abort a 32-bit op with reset while inputs churn; valid is asserted with reset.
    @(negedge g_clk);
    pw    = 5'b00001;
    lhs   = 32'hFFFF_FFFF;
    rhs   = 32'hFFFF_FFFF;
    valid = 1'b1;
    @(negedge g_clk);
    valid = 1'b0;
    for (int i = 2; i < 10; i++) begin
      @(negedge g_clk);
      lhs   = $urandom;
      rhs   = $urandom;
      valid = 1'($urandom_range(0, 1));
    end
    @(negedge g_clk);
    g_reset = 1'b1;
    valid   = 1'b1;
    pw      = 5'b10000;
    @(negedge g_clk);
    check("abort_ready", 64'(ready), 64'd0);
    check("abort_lo", 64'(result_lo), 64'd0);
    check("abort_hi", 64'(result_hi), 64'd0);
    g_reset = 1'b0;
    valid   = 1'b0;
    seen    = 0;
    repeat (6) begin
      @(negedge g_clk);
      if (ready === 1'b1) seen++;
    end
    check("no_capture_under_reset", 64'(seen), 64'd0);
    run_one(table_v[4]);

    // valid held high: captures every W+2 = 10 cycles.
    @(negedge g_clk);
    for (int k = 0; k < 3; k++) begin
      v.pw  = 5'b00100;
      v.lhs = (k == 0) ? 32'h0210_FF00 : $urandom;
      v.rhs = (k == 0) ? 32'h8010_FF7F : $urandom;
      model(v.pw, v.lhs, v.rhs, lo, hi);
      drive(v.pw, v.lhs, v.rhs, lo, hi);
      if (k < 2) repeat (10) @(negedge g_clk);
    end
    @(negedge g_clk);
    valid = 1'b0;
    while (sbq.size() != 0 && seen < 200) begin
      @(negedge g_clk);
      #1;
      seen++;
    end
    if (sbq.size() != 0) begin
      check("b2b_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    repeat (3) @(negedge g_clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/p_mul.md
# p_mul

Multi-cycle packed unsigned multiplier for 32-bit operands, split into 1×32, 2×16, 4×8, 8×4 or 16×2-bit lanes. It sits next to the packed add/sub unit in the packed-arithmetic datapath and drives an internal lane-masked adder with a per-lane carry chain. Each lane runs shift-and-add and produces a full 2W-bit product, returned as separate packed low and high words. One operation is in flight at a time, under a valid/ready handshake.

## Interface
Parameters: none.
- g_clk  input  1  clock; all state updates on rising edge
- g_reset  input  1  synchronous, active-high reset
- valid  input  1  request; sampled only in IDLE
- lhs  input  32  multiplier operand, packed lanes
- rhs  input  32  multiplicand operand, packed lanes
- pw  input  5  one-hot pack width: bit0=32, bit1=16, bit2=8, bit3=4, bit4=2
- ready  output  1  result valid; high for exactly one cycle per operation
- result_lo  output  32  packed low halves of lane products
- result_hi  output  32  packed high halves of lane products

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE. Outputs on reset: ready=0, result_lo=0, result_hi=0, counter=0.
- Lane width W is decoded from the lowest set bit of pw. pw=0 is treated as W=32. Multi-hot pw uses the lowest set bit.
- IDLE with valid=1:
  - Capture A=lhs, B=rhs and W.
  - Clear P_hi and P_lo, set counter=W-1.
  - Go to BUSY.
- IDLE with valid=0: hold state.
- BUSY, every cycle, independently per lane k:
  - sum_k = P_hi_k + (A_k[0] ? B_k : 0). The sum is W+1 bits and its carry is lane-local: no carry may cross a lane boundary.
  - {P_hi_k, P_lo_k} ← {sum_k, P_lo_k} >> 1, using a lane-local shift. Bit 0 of sum_k enters the MSB of P_lo_k.
  - A_k ← A_k >> 1, lane-local, zero-filled.
  - Counter decrements. When the counter is 0 in BUSY, the next state is DONE.
- DONE:
  - ready=1, with result_lo=P_lo and result_hi=P_hi.
  - Next state is IDLE unconditionally.
- Results are held in their registers after DONE until the next capture clears them, so they stay stable but are only guaranteed during ready.
- Result per lane k: product p_k = A_k × B_k, unsigned and 2W bits. result_lo lane k = p_k[W-1:0]; result_hi lane k = p_k[2W-1:W].
- valid is ignored in BUSY and DONE; there is no abort. The requester must drop valid in the cycle ready is seen, or a new operation starts from IDLE with the current inputs.
- Inputs are only sampled at capture; lhs, rhs and pw may change during BUSY with no effect.

## Timing
- Valid is sampled high in IDLE at edge N. BUSY covers edges N+1 … N+W. ready is high in the cycle after edge N+W.
- Latency from the sampling edge to ready is W+1 cycles: 33, 17, 9, 5 or 3 for pw 32/16/8/4/2.
- Minimum request-to-request spacing is W+2 cycles, since DONE always passes through IDLE.
- Reset mid-operation (any state): next cycle is IDLE, ready=0, results=0, and the in-flight op is discarded.
- Simultaneous reset and valid: reset wins, and no capture occurs.

## Test plan
- pw=00001, lhs=rhs=0xFFFFFFFF, valid pulsed 1 cycle → ready exactly 33 cycles later for 1 cycle, result_hi=0xFFFFFFFE, result_lo=0x00000001.
- pw=00010, lhs=0x0003FFFF, rhs=0x0005FFFF → ready after 17 cycles, result_lo=0x000F0001, result_hi=0x0000FFFE (checks that no carry crosses the lane boundary).
- pw=00100, lhs=0x0210FF00, rhs=0x8010FF7F → ready after 9 cycles, result_lo=0x00000100, result_hi=0x0101FE00.
- pw=10000, lhs=rhs=0xFFFFFFFF → ready after 3 cycles, result_lo=0x55555555, result_hi=0xAAAAAAAA.
- Start pw=00001 op, toggle lhs/rhs/valid during BUSY, assert g_reset at cycle 10 → ready=0 and results=0 next cycle. Then valid with pw=01000, lhs=rhs=0xFFFFFFFF → ready after 5 cycles, result_lo=0x11111111, result_hi=0xEEEEEEEE.
- valid held high continuously with pw=00100 → back-to-back operations, with ready pulses every 10 cycles, each with correct results.
